// File: rtl/cs_arb_pkg.sv
// cs_arb_pkg: shared sizes, FSM state type and grant encoding for the chip-select arbiter
package cs_arb_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;
    typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
    // Active-low one-hot select pattern for one requester
    function automatic logic [N_REQ-1:0] onehot_n(input logic [IDX_W-1:0] idx);
        return ~(N_REQ'(1) << idx);
    endfunction
endpackage

// File: rtl/rr_pick16.sv
// rr_pick16: combinational round-robin pick of the first request at or after ptr
//   req [15:0] in  - active-high requests
//   ptr [3:0]  in  - highest-priority position
//   any        out - at least one request present
//   idx [3:0]  out - chosen requester, meaningful only when any=1
module rr_pick16
    import cs_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    // Rotating right by ptr puts requester ptr at bit 0, so a fixed
    // lowest-bit-first encoder yields the round-robin offset from ptr.
    assign dbl = {req, req} >> ptr;
    assign rot = dbl[N_REQ-1:0];
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
    end
    assign any = |req;
    assign idx = ptr + off;
endmodule

// File: rtl/cs_rr_arbiter16.sv
// cs_rr_arbiter16: round-robin arbiter driving a 16-way active-low chip-select bus
//   clk            in  - rising-edge clock
//   rst            in  - synchronous active-high reset
//   en             in  - low forces all grants off
//   req [15:0]     in  - active-high requests
//   gnt_n [15:0]   out - registered active-low one-hot grant, all ones = none
//   gnt_idx [3:0]  out - current grantee, holds last value when gnt_valid=0
//   gnt_valid      out - high while a grant is driven
module cs_rr_arbiter16
    import cs_arb_pkg::*;
#(
    parameter int MAX_HOLD   = 8,
    parameter int GAP_CYCLES = 1,
    parameter int HOLD_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt_n,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_t        state, state_d;
    logic [IDX_W-1:0]  ptr, ptr_d, pick, idx_d;
    logic [HOLD_W-1:0] hold_cnt, hold_d;
    logic [GAP_W-1:0]  gap_cnt, gap_d;
    logic [N_REQ-1:0]  gnt_n_d;
    logic              valid_d, any, others;

    rr_pick16 u_pick (
        .req (req),
        .ptr (ptr),
        .any (any),
        .idx (pick)
    );

    assign others = |(req & onehot_n(gnt_idx));

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        hold_d  = hold_cnt;
        gap_d   = gap_cnt;
        gnt_n_d = gnt_n;
        idx_d   = gnt_idx;
        valid_d = gnt_valid;
        case (state)
            IDLE: if (en && any) begin
                state_d = GRANT;
                idx_d   = pick;
                gnt_n_d = onehot_n(pick);
                valid_d = 1'b1;
                hold_d  = '0;
            end
            GRANT: if (!en) begin
                // Enable drop keeps ptr so the same requester wins again first
                state_d = IDLE;
                gnt_n_d = '1;
                valid_d = 1'b0;
            end else if (!req[gnt_idx] || (hold_cnt == HOLD_MAX && others)) begin
                state_d = GAP;
                gnt_n_d = '1;
                valid_d = 1'b0;
                ptr_d   = gnt_idx + IDX_W'(1);
                gap_d   = '0;
            end else if (hold_cnt != HOLD_MAX) begin
                hold_d = hold_cnt + HOLD_W'(1);
            end
            GAP: if (!en || gap_cnt == GAP_LAST) state_d = IDLE;
                 else gap_d = gap_cnt + GAP_W'(1);
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt_n     <= '1;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            hold_cnt  <= hold_d;
            gap_cnt   <= gap_d;
            gnt_n     <= gnt_n_d;
            gnt_idx   <= idx_d;
            gnt_valid <= valid_d;
        end
    end
endmodule

// File: tb/tb_cs_rr_arbiter16.sv
// tb_cs_rr_arbiter16: directed self-checking bench for cs_rr_arbiter16
module tb_cs_rr_arbiter16;
    logic        clk = 1'b0;
    logic        rst, en;
    logic [15:0] req, gnt_n;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    int          checks = 0;
    int          errors = 0;

    cs_rr_arbiter16 dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt_n     (gnt_n),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic grant_is(input string tag, input logic [3:0] idx, input logic [15:0] pat);
        check({tag, "_gnt_n"}, 32'(gnt_n), 32'(pat));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(idx));
        check({tag, "_valid"}, 32'(gnt_valid), 32'd1);
    endtask

    task automatic none(input string tag);
        check({tag, "_gnt_n"}, 32'(gnt_n), 32'hFFFF);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = '0;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        none("reset");
        check("reset_idx", 32'(gnt_idx), 32'd0);

        // Single requester, then release: two guard cycles
        req = 16'h0001;
        step(1);
        grant_is("t1_grant", 4'd0, 16'hFFFE);
        req = '0;
        step(1);
        none("t1_gap0");
        step(1);
        none("t1_gap1");

        // Enable low in IDLE blocks grants
        en  = 1'b0;
        req = 16'h0001;
        step(2);
        none("en_low_idle");
        en = 1'b1;

        // Fairness with pointer wrap 15 -> 0
        do_reset();
        req = 16'h8001;
        step(1);
        grant_is("t2_a", 4'd0, 16'hFFFE);
        step(1);
        req = 16'h8000;
        step(1);
        none("t2_gap_a0");
        step(1);
        none("t2_gap_a1");
        req = 16'h8001;
        step(1);
        grant_is("t2_b", 4'd15, 16'h7FFF);
        step(1);
        req = 16'h0001;
        step(1);
        none("t2_gap_b0");
        check("t2_idx_hold", 32'(gnt_idx), 32'd15);
        step(1);
        none("t2_gap_b1");
        req = 16'h8001;
        step(1);
        grant_is("t2_c", 4'd0, 16'hFFFE);

        // Preemption after eight grant cycles
        do_reset();
        req = 16'h0003;
        step(1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++) begin
                if (r[0]) grant_is($sformatf("t3_r%0d_k%0d", r, k), 4'd1, 16'hFFFD);
                else      grant_is($sformatf("t3_r%0d_k%0d", r, k), 4'd0, 16'hFFFE);
                step(1);
            end
            none($sformatf("t3_r%0d_gap0", r));
            step(1);
            none($sformatf("t3_r%0d_gap1", r));
            step(1);
        end

        // Sole holder keeps the grant indefinitely
        do_reset();
        req = 16'h0020;
        step(1);
        for (int k = 0; k < 50; k++) begin
            check($sformatf("t4_k%0d", k), 32'(gnt_n), 32'hFFDF);
            step(1);
        end

        // Enable drop keeps ptr at 3
        do_reset();
        req = 16'h0004;
        step(1);
        grant_is("t5_pre", 4'd2, 16'hFFFB);
        req = '0;
        step(2);
        req = 16'h0008;
        step(1);
        grant_is("t5_g3", 4'd3, 16'hFFF7);
        step(1);
        en = 1'b0;
        step(1);
        none("t5_en_drop");
        en  = 1'b1;
        req = 16'h0018;
        step(1);
        grant_is("t5_regrant", 4'd3, 16'hFFF7);

        // Reset mid-grant
        do_reset();
        req = 16'h0080;
        step(1);
        grant_is("t6_g7", 4'd7, 16'hFF7F);
        step(1);
        rst = 1'b1;
        step(1);
        none("t6_rst");
        check("t6_rst_idx", 32'(gnt_idx), 32'd0);
        rst = 1'b0;
        req = '0;
        step(1);
        req = 16'h0081;
        step(1);
        grant_is("t6_after", 4'd0, 16'hFFFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
